prbs_dbi_ctrl: RTL and testbench

PRBS_DBI_CTRL -- requirements
Module: prbs_dbi_ctrl

---
 rtl/prbs_pkg.sv | 25 ++
 rtl/prbs_dbi_step.sv | 23 ++
 rtl/prbs_dbi_ctrl.sv | 151 +++++++++++++++
 tb/tb_prbs_dbi_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared FSM state type, PRBS polynomial taps and DBI defaults for the
// prbs_dbi_ctrl block.
package prbs_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    RUN,
    DRAIN,
    DONE
  } state_e;

  // x^16+x^15+x^13+x^4 in right-shift form: feedback taps s[0], s[1], s[3], s[12]
  localparam logic [15:0] PRBS_TAPS      = 16'h100B;
  localparam logic [15:0] PRBS_SEED_DEF  = 16'h0001;
  localparam int          DBI_THRESH_DEF = 7;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/prbs_dbi_step.sv
// One combinational LFSR step followed by data-bus inversion; the returned
// word is also the next generator state.
module prbs_dbi_step
  import prbs_pkg::*;
#(
  parameter int N          = 16,
  parameter int DBI_THRESH = DBI_THRESH_DEF
) (
  input  logic [N-1:0] s,
  output logic [N-1:0] word,
  output logic         dbi
);

  logic         fb;
  logic [N-1:0] raw;

  assign fb   = ^(s & N'(PRBS_TAPS));
  assign raw  = {fb, s[N-1:1]};
  // Invert when more than DBI_THRESH lines would toggle against the last word.
  assign dbi  = popcount16(16'(raw ^ s)) > 5'(DBI_THRESH);
  assign word = dbi ? ~raw : raw;

endmodule

// File: rtl/prbs_dbi_ctrl.sv
// PRBS-16 transmit controller with DBI encoding; the loopback receive checker
// is built only when PRBS_CHECKER_EN is defined.
module prbs_dbi_ctrl
  import prbs_pkg::*;
#(
  parameter int N          = 16,
  parameter int DBI_THRESH = DBI_THRESH_DEF,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [N-1:0]     seed,
  input  logic [CNT_W-1:0] len,
  output logic [N-1:0]     tx_data,
  output logic             tx_dbi,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [N-1:0]     rx_data,
  input  logic             rx_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count
);

  state_e           state_q;
  logic [N-1:0]     seed_q, s_q, tx_data_q, gen_word;
  logic [CNT_W-1:0] len_q, tx_cnt_q, tx_cnt_d;
  logic             tx_dbi_q, tx_valid_q, done_q, gen_dbi, drain_done;

  prbs_dbi_step #(.N(N), .DBI_THRESH(DBI_THRESH)) u_gen (
    .s    (s_q),
    .word (gen_word),
    .dbi  (gen_dbi)
  );

  assign tx_cnt_d = tx_cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      seed_q     <= N'(PRBS_SEED_DEF);
      s_q        <= N'(PRBS_SEED_DEF);
      len_q      <= '0;
      tx_cnt_q   <= '0;
      tx_data_q  <= '0;
      tx_dbi_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else if (abort) begin
      // Abort also blocks a coincident start while idle.
      state_q    <= IDLE;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          seed_q  <= (seed == '0) ? N'(PRBS_SEED_DEF) : seed;
          len_q   <= len;
          state_q <= SEED;
        end
        SEED: begin
          s_q        <= seed_q;
          tx_cnt_q   <= '0;
          tx_valid_q <= 1'b0;
          state_q    <= (len_q == '0) ? DRAIN : RUN;
        end
        RUN: begin
          if (!tx_valid_q) begin
            tx_data_q  <= gen_word;
            tx_dbi_q   <= gen_dbi;
            s_q        <= gen_word;
            tx_valid_q <= 1'b1;
          end else if (tx_ready) begin
            tx_cnt_q <= tx_cnt_d;
            if (tx_cnt_d == len_q) begin
              tx_valid_q <= 1'b0;
              state_q    <= DRAIN;
            end else begin
              tx_data_q <= gen_word;
              tx_dbi_q  <= gen_dbi;
              s_q       <= gen_word;
            end
          end
        end
        DRAIN: if (drain_done) state_q <= DONE;
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef PRBS_CHECKER_EN
  logic [N-1:0]     exp_q, exp_word;
  logic             exp_dbi_unused;
  logic [CNT_W-1:0] rx_cnt_q, err_q, err_d;
  logic             rx_take;

  prbs_dbi_step #(.N(N), .DBI_THRESH(DBI_THRESH)) u_chk (
    .s    (exp_q),
    .word (exp_word),
    .dbi  (exp_dbi_unused)
  );

  // Words past len are dropped so a late loopback cannot skew the count.
  assign rx_take = (state_q == RUN || state_q == DRAIN) && rx_valid && (rx_cnt_q != len_q);

  always_comb begin
    err_d = err_q;
    if (rx_take && (rx_data != exp_word) && (err_q != '1)) err_d = err_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exp_q    <= N'(PRBS_SEED_DEF);
      rx_cnt_q <= '0;
      err_q    <= '0;
    end else if (!abort) begin
      if (state_q == SEED) begin
        exp_q    <= seed_q;
        rx_cnt_q <= '0;
        err_q    <= '0;
      end else if (rx_take) begin
        exp_q    <= exp_word;
        rx_cnt_q <= rx_cnt_q + CNT_W'(1);
        err_q    <= err_d;
      end
    end
  end

  assign drain_done = (rx_cnt_q == len_q);
  assign err_count  = err_q;
`else
  logic unused_rx;
  assign unused_rx  = ^{rx_data, rx_valid};
  assign drain_done = 1'b1;
  assign err_count  = '0;
`endif

  assign tx_data  = tx_data_q;
  assign tx_dbi   = tx_dbi_q;
  assign tx_valid = tx_valid_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_prbs_dbi_ctrl.sv
// Randomized bench for prbs_dbi_ctrl: a transaction-level model (word list,
// phase, counters) checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_prbs_dbi_ctrl;

`ifdef PRBS_CHECKER_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int ERR_MAX = 65535;

  logic        clk = 1'b0;
  logic        reset, start, abort, tx_ready;
  logic [15:0] seed, len;
  logic [15:0] tx_data, err_count;
  logic        tx_dbi, tx_valid, busy, done;
  logic [15:0] rx_data = 16'h0;
  logic        rx_valid = 1'b0;

  always #5 clk = ~clk;

  prbs_dbi_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .seed(seed), .len(len),
    .tx_data(tx_data), .tx_dbi(tx_dbi), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .done(done), .err_count(err_count)
  );

  int n_vec = 0, n_bad = 0;

  task automatic chk1(input string nm, input logic act, input logic want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b, expected %b", nm, $time, act, want);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, want);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int want);
    n_vec++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, want);
    end
  endtask

  // Spec step rule: shift in feedback, invert if more than 7 lines toggle.
  function automatic logic [16:0] prbs_next(input logic [15:0] s);
    logic [15:0] raw;
    int ones;
    raw  = {s[0] ^ s[1] ^ s[3] ^ s[12], s[15:1]};
    ones = 0;
    for (int i = 0; i < 16; i++) if (raw[i] != s[i]) ones++;
    if (ones > 7) return {1'b1, ~raw};
    return {1'b0, raw};
  endfunction

  // Model: phase 0 idle, 1 seeding, 2 sending, 3 draining, 4 finishing.
  int          m_ph = 0, m_oph = 0, m_len = 0, m_sent = 0, m_rx = 0, m_err = 0;
  bit          m_valid = 1'b0, m_done = 1'b0;
  logic [15:0] m_seed, m_s;
  logic [16:0] m_r;
  logic [16:0] wl[$];

  always @(posedge clk) begin
    m_oph  = m_ph;
    m_done = 1'b0;
    if (reset) begin
      m_ph = 0; m_valid = 1'b0; m_err = 0; m_sent = 0; m_rx = 0;
    end else if (abort) begin
      m_ph = 0; m_valid = 1'b0;
    end else begin
      case (m_oph)
        0: if (start) begin
          m_seed = (seed == 16'h0) ? 16'h0001 : seed;
          m_len  = int'(len);
          m_ph   = 1;
        end
        1: begin
          wl.delete();
          m_s = m_seed;
          for (int k = 0; k < m_len; k++) begin
            m_r = prbs_next(m_s);
            wl.push_back(m_r);
            m_s = m_r[15:0];
          end
          m_sent = 0; m_rx = 0; m_err = 0; m_valid = 1'b0;
          m_ph = (m_len == 0) ? 3 : 2;
        end
        2: begin
          if (!m_valid) m_valid = 1'b1;
          else if (tx_ready) begin
            m_sent++;
            if (m_sent == m_len) begin m_valid = 1'b0; m_ph = 3; end
          end
        end
        3: if (!CHK || m_rx == m_len) m_ph = 4;
        default: begin m_done = 1'b1; m_ph = 0; end
      endcase
      if (CHK && (m_oph == 2 || m_oph == 3) && rx_valid && m_rx < m_len) begin
        if (rx_data != wl[m_rx][15:0] && m_err < ERR_MAX) m_err++;
        m_rx++;
      end
    end
  end

  bit chk_en = 1'b0;
  always @(negedge clk) if (chk_en) begin
    chk1("tx_valid", tx_valid, m_valid);
    chk1("busy", busy, m_ph != 0);
    chk1("done", done, m_done);
    chk16("err_count", err_count, 16'(m_err));
    if (m_valid) begin
      chk16("tx_data", tx_data, wl[m_sent][15:0]);
      chk1("tx_dbi", tx_dbi, wl[m_sent][16]);
    end
  end

  int dn_cnt = 0;
  always @(negedge clk) if (done === 1'b1) dn_cnt++;

  // Loopback: echoes transferred words back on rx with random gaps.
  logic [15:0] lbq[$];
  bit lb_flush = 1'b0, lb_junk = 1'b0;
  int lb_idx = 0, flip_at = -1, rx_pct = 70;
  always @(negedge clk) begin
    if (lb_flush) begin
      lbq.delete(); lb_idx = 0; rx_valid = 1'b0;
    end else begin
      if (lb_junk) begin
        rx_valid = 1'($urandom_range(0, 1));
        rx_data  = 16'($urandom);
      end else if (lbq.size() > 0 && $urandom_range(0, 99) < rx_pct) begin
        rx_data = lbq.pop_front();
        if (lb_idx == flip_at) rx_data = rx_data ^ 16'h0100;
        lb_idx++;
        rx_valid = 1'b1;
      end else begin
        rx_valid = 1'b0;
        rx_data  = 16'($urandom);
      end
      if (tx_valid && tx_ready) lbq.push_back(tx_data);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] sd, input logic [15:0] ln);
    seed = sd; len = ln; start = 1'b1; lb_flush = 1'b1;
    cyc();
    start = 1'b0; lb_flush = 1'b0;
    seed = 16'($urandom); len = 16'($urandom);
  endtask

  task automatic wait_idle(input int pct, input int budget);
    int k;
    k = 0;
    while (m_ph != 0 && k < budget) begin
      tx_ready = ($urandom_range(0, 99) < pct);
      start    = ($urandom_range(0, 15) == 0);
      seed     = 16'($urandom);
      len      = 16'($urandom);
      cyc();
      k++;
    end
    start = 1'b0;
    if (m_ph != 0) begin
      n_vec++; n_bad++;
      $display("FAIL run_timeout @%0t: still busy after %0d cycles, expected idle", $time, budget);
      reset = 1'b1; cyc(); reset = 1'b0;
    end
    cyc();
  endtask

  task automatic two_word(input logic [15:0] sd, input string tag);
    int d0;
    tx_ready = 1'b1;
    d0 = dn_cnt;
    do_start(sd, 16'd2);
    cyc();
    chk1({tag, "_busy"}, busy, 1'b1);
    chk1({tag, "_nv"}, tx_valid, 1'b0);
    chk16({tag, "_model_w0"}, wl[0][15:0], 16'h8000);
    chk16({tag, "_model_w1"}, wl[1][15:0], 16'h4000);
    cyc();
    chk1({tag, "_v0"}, tx_valid, 1'b1);
    chk16({tag, "_w0"}, tx_data, 16'h8000);
    chk1({tag, "_dbi0"}, tx_dbi, 1'b0);
    cyc();
    chk1({tag, "_v1"}, tx_valid, 1'b1);
    chk16({tag, "_w1"}, tx_data, 16'h4000);
    chk1({tag, "_dbi1"}, tx_dbi, 1'b0);
    cyc();
    chk1({tag, "_vdrop"}, tx_valid, 1'b0);
    wait_idle(100, 200);
    chk_int({tag, "_done_cnt"}, dn_cnt - d0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog @%0t: simulation did not finish", $time);
    $fatal(1);
  end

  initial begin
    int d0, k;
    logic [15:0] saved;
    logic [15:0] rsd;
    int rln;
    reset = 1'b1; start = 1'b0; abort = 1'b0; tx_ready = 1'b0;
    seed = 16'h0; len = 16'h0;
    repeat (3) cyc();
    chk_en = 1'b1;
    chk16("rst_tx_data", tx_data, 16'h0);
    chk1("rst_tx_dbi", tx_dbi, 1'b0);
    chk1("rst_tx_valid", tx_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk16("rst_err", err_count, 16'h0);
    reset = 1'b0;
    cyc();

    two_word(16'h0001, "seed1");
    two_word(16'h0000, "seed0");

    // Backpressure on the first word.
    tx_ready = 1'b0;
    do_start(16'h0001, 16'd3);
    cyc();
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk1("stall_valid", tx_valid, 1'b1);
      chk16("stall_data", tx_data, 16'h8000);
      cyc();
    end
    tx_ready = 1'b1;
    cyc();
    chk16("resume_data", tx_data, 16'h4000);
    wait_idle(100, 200);

    // Zero-length run.
    d0 = dn_cnt;
    do_start(16'($urandom), 16'd0);
    cyc(); chk1("len0_done_c1", done, 1'b0);
    cyc(); chk1("len0_done_c2", done, 1'b0);
    cyc(); chk1("len0_done_c3", done, 1'b1);
    chk1("len0_busy", busy, 1'b0);
    chk16("len0_err", err_count, 16'h0);
    cyc();
    chk_int("len0_done_cnt", dn_cnt - d0, 1);

    // Long loopback with one corrupted receive word.
    d0 = dn_cnt;
    flip_at = 37;
    do_start(16'hACE1, 16'd100);
    wait_idle(80, 3000);
    flip_at = -1;
    chk16("flip_err", err_count, CHK ? 16'd1 : 16'd0);
    chk_int("flip_done_cnt", dn_cnt - d0, 1);

    // Abort after 10 words.
    d0 = dn_cnt;
    tx_ready = 1'b1;
    do_start(16'($urandom), 16'd30);
    k = 0;
    while (m_sent < 10 && k < 100) begin cyc(); k++; end
    if (m_sent < 10) begin
      n_vec++; n_bad++;
      $display("FAIL abort_wait @%0t: sent %0d words, expected 10", $time, m_sent);
    end
    saved = 16'(m_err);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk1("abort_valid", tx_valid, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chk16("abort_err_held", err_count, saved);
    repeat (4) cyc();
    chk_int("abort_no_done", dn_cnt - d0, 0);

    // Reset in the middle of a run.
    d0 = dn_cnt;
    do_start(16'($urandom), 16'd30);
    repeat (8) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk1("mrst_valid", tx_valid, 1'b0);
    chk1("mrst_busy", busy, 1'b0);
    chk16("mrst_data", tx_data, 16'h0);
    chk16("mrst_err", err_count, 16'h0);
    repeat (4) cyc();
    chk_int("mrst_no_done", dn_cnt - d0, 0);

    // Random runs with idle-time rx noise in between.
    for (int r = 0; r < 10; r++) begin
      lb_junk = 1'b1;
      repeat (3) cyc();
      lb_junk = 1'b0;
      rsd = (r % 4 == 0) ? 16'h0 : 16'($urandom);
      rln = $urandom_range(0, 40);
      flip_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, rln) : -1;
      rx_pct = $urandom_range(40, 100);
      d0 = dn_cnt;
      do_start(rsd, 16'(rln));
      wait_idle($urandom_range(25, 100), 1500);
      chk_int("rand_done_cnt", dn_cnt - d0, 1);
    end
    flip_at = -1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
